// File: rtl/uart_pkg.sv
// Shared UART definitions: default character width, TX FIFO depth and
// the almost-full threshold rule used by the transmit FIFO.
package uart_pkg;

  localparam int unsigned UART_DATA_W    = 8;
  localparam int unsigned UART_TXF_DEPTH = 16;

  // Two entries of headroom, but never below 1 so tiny FIFOs stay legal.
  function automatic int unsigned txf_af_level(input int unsigned depth);
    return (depth > 2) ? depth - 2 : 1;
  endfunction

endpackage

// File: rtl/tx_fifo_mem.sv
// Simple dual-port storage for the TX FIFO: synchronous write, registered read.
// The array itself carries no reset so it can map onto RAM primitives.
module tx_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = UART_TXF_DEPTH
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read-before-write: a simultaneous pop and push at the same address returns the old word.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the host write port and the UART serializer:
// occupancy/status decode, push/pop arbitration and sticky error flags.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W   = UART_DATA_W,
  parameter int unsigned DEPTH    = UART_TXF_DEPTH,
  parameter int unsigned AF_LEVEL = txf_af_level(DEPTH)
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("uart_tx_fifo: AF_LEVEL must lie in 1..DEPTH");
  end
  if ((DATA_W < 5) || (DATA_W > 9)) begin : g_bad_width
    $error("uart_tx_fifo: DATA_W must lie in 5..9");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          rd_valid_q, rd_valid_d;
  logic          push_ok, pop_ok;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AF_LEVEL));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // alongside it; clr suppresses both.
  always_comb begin
    pop_ok  = rd_en & ~empty & ~clr;
    push_ok = wr_en & (~full | pop_ok) & ~clr;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rd_valid_d  = pop_ok;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q | (wr_en & full & ~pop_ok);
      underflow_d = underflow_q | (rd_en & empty);
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  tx_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .areset(areset),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (pop_ok),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a 16x8 instance (vector table plus corner
// sequences) and a 4x9 instance for the small-depth wrap case.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  logic       clr = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = '0, rd_data;
  logic       rd_valid, full, almost_full, empty, overflow, underflow;
  logic [4:0] count;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .areset(areset), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .almost_full(almost_full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  logic       s_clr = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
  logic [8:0] s_wr_data = '0, s_rd_data;
  logic       s_rd_valid, s_full, s_almost_full, s_empty, s_overflow, s_underflow;
  logic [2:0] s_count;

  uart_tx_fifo #(.DATA_W(9), .DEPTH(4)) dut_s (
    .clk(clk), .areset(areset), .clr(s_clr), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
    .almost_full(s_almost_full), .empty(s_empty), .count(s_count),
    .overflow(s_overflow), .underflow(s_underflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       wr, rd, cl;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       emp, ful, rv;
    logic [7:0] rdd;
    logic       ovf, unf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr_en = w; rd_en = r; clr = c; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic scyc(input logic w, input logic r, input logic [8:0] d);
    s_wr_en = w; s_rd_en = r; s_wr_data = d;
    @(posedge clk); #1;
    s_wr_en = 1'b0; s_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs [12];
    logic [7:0] q [$];
    logic [8:0] sq [$];
    logic [7:0] d;
    logic [8:0] sd;

    // Reset state
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_af", 32'(almost_full), 0);
    check("rst_rv", 32'(rd_valid), 0);
    check("rst_rdata", 32'(rd_data), 0);
    check("rst_flags", {30'd0, overflow, underflow}, 0);
    check("rst_s_empty", 32'(s_empty), 1);
    areset = 1'b0;

    // Fill 0x41..0x50
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(8'h41 + i));
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_af", 32'(almost_full), 32'((i + 1) >= 14));
      check("fill_full", 32'(full), 32'(i == 15));
    end
    check("fill_empty", 32'(empty), 0);

    // Full with simultaneous push/pop
    cyc(1'b1, 1'b1, 1'b0, 8'h77);
    check("fullrw_rv", 32'(rd_valid), 1);
    check("fullrw_rd", 32'(rd_data), 32'h41);
    check("fullrw_count", 32'(count), 16);
    check("fullrw_ovf", 32'(overflow), 0);

    // Push while full, no pop
    cyc(1'b1, 1'b0, 1'b0, 8'hAA);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_count", 32'(count), 16);

    // Drain: 0x42..0x50 then 0x77, 0xAA never appears
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check("drain_rv", 32'(rd_valid), 1);
      check("drain_rd", 32'(rd_data), (i == 15) ? 32'h77 : 32'(8'h42 + i));
    end
    check("drain_empty", 32'(empty), 1);
    check("drain_ovf_sticky", 32'(overflow), 1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    check("idle_rv", 32'(rd_valid), 0);

    // Empty corner cases
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("unf_flag", 32'(underflow), 1);
    check("unf_rv", 32'(rd_valid), 0);
    check("unf_rd_hold", 32'(rd_data), 32'h77);
    cyc(1'b1, 1'b1, 1'b0, 8'h33);
    check("emptyrw_count", 32'(count), 1);
    check("emptyrw_rv", 32'(rd_valid), 0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("emptyrw_pop", 32'(rd_data), 32'h33);
    check("emptyrw_pop_rv", 32'(rd_valid), 1);

    // Vector table: clr, interleaved push/pop, underflow, clr beating a write
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h10, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h12, 5'd2, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h13, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h55, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].wr, vecs[i].rd, vecs[i].cl, vecs[i].d);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_flags", i), {28'd0, empty, full, overflow, underflow},
            {28'd0, vecs[i].emp, vecs[i].ful, vecs[i].ovf, vecs[i].unf});
      check($sformatf("vec%0d_rv", i), 32'(rd_valid), 32'(vecs[i].rv));
      if (vecs[i].rv) check($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(vecs[i].rdd));
    end

    // 40 pushes with overlapped pops and idle gaps: pointers wrap twice
    for (int i = 0; i < 40; i++) begin
      d = 8'((i * 29 + 7) & 8'hFF);
      cyc(1'b1, (i > 0), 1'b0, d);
      if (i > 0) check("wrap_rd", 32'(rd_data), 32'(q.pop_front()));
      q.push_back(d);
      check("wrap_count", 32'(count), 1);
      if (i % 5 == 0) cyc(1'b0, 1'b0, 1'b0, 8'h00);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("wrap_last", 32'(rd_data), 32'(q.pop_front()));
    check("wrap_empty", 32'(empty), 1);

    // Small instance: DEPTH=4, DATA_W=9, AF_LEVEL=2
    for (int i = 0; i < 4; i++) begin
      scyc(1'b1, 1'b0, 9'(9'h100 + i));
      check("s_fill_count", 32'(s_count), 32'(i + 1));
      check("s_fill_af", 32'(s_almost_full), 32'(i >= 1));
    end
    check("s_full", 32'(s_full), 1);
    scyc(1'b1, 1'b0, 9'h1FF);
    check("s_ovf", 32'(s_overflow), 1);
    check("s_ovf_count", 32'(s_count), 4);
    for (int i = 0; i < 4; i++) begin
      scyc(1'b0, 1'b1, 9'h000);
      check("s_drain", 32'(s_rd_data), 32'(9'h100 + i));
    end
    check("s_empty", 32'(s_empty), 1);
    for (int i = 0; i < 40; i++) begin
      sd = 9'((i * 37 + 256) % 512);
      scyc(1'b1, (i > 0), sd);
      if (i > 0) check("s_wrap_rd", 32'(s_rd_data), 32'(sq.pop_front()));
      sq.push_back(sd);
      if (i % 3 == 0) scyc(1'b0, 1'b0, 9'h000);
    end
    scyc(1'b0, 1'b1, 9'h000);
    check("s_wrap_last", 32'(s_rd_data), 32'(sq.pop_front()));

    // Asynchronous reset mid-stream at count=5
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("pre_rst_count", 32'(count), 5);
    #3 areset = 1'b1;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_empty", 32'(empty), 1);
    check("arst_flags", {30'd0, overflow, underflow}, 0);
    check("arst_rv", 32'(rd_valid), 0);
    #1 areset = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("post_rst_unf", 32'(underflow), 1);
    check("post_rst_rv", 32'(rd_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, single-clock transmit FIFO between the host write interface and the UART transmitter serializer. It buffers DATA_W-bit characters in a DEPTH-entry circular store and reports exact occupancy, full, empty and almost-full status. It also reports sticky overflow/underflow errors. All state changes occur on clk and are qualified by enables, so the serializer pops with a one-cycle pulse instead of clocking the FIFO from its baud strobe.

## Interface
- DATA_W, 8, character width in bits (5..9 legal)
- DEPTH, 16, number of entries; power of two, >= 2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH
- clk  in  1  rising-edge clock
- areset  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous flush: pointers, count and sticky flags to zero; memory untouched
- wr_en  in  1  push request
- wr_data  in  DATA_W  push data
- rd_en  in  1  pop request from serializer
- rd_data  out  DATA_W  registered pop data
- rd_valid  out  1  one-cycle pulse: rd_data updated this cycle
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: push attempted while full and not popped
- underflow  out  1  sticky: pop attempted while empty

## Operation
- AW = $clog2(DEPTH); wr_ptr, rd_ptr are AW bits and wrap modulo DEPTH naturally; count is AW+1 bits
- push_ok = wr_en & (~full | pop_ok); pop_ok = rd_en & ~empty
- push_ok: mem[wr_ptr] <= wr_data, wr_ptr++
- pop_ok: rd_data <= mem[rd_ptr], rd_ptr++, rd_valid = 1 next cycle
- count next: +1 on push only, -1 on pop only, unchanged on both or neither
- Full with wr_en & rd_en: both accepted, count stays DEPTH, no overflow
- Empty with wr_en & rd_en: write accepted, read rejected (no fall-through), underflow set, count -> 1
- wr_en while full without pop: data dropped, pointers unchanged, overflow <= 1
- rd_en while empty: rd_data holds last value, rd_valid stays 0, underflow <= 1
- Sticky flags clear only on areset or clr
- clr has priority over wr_en and rd_en in the same cycle: nothing pushed or popped, rd_valid = 0
- full, empty and almost_full are combinational decodes of the count register, glitch-free relative to clk

## Timing
- Reset (areset high, asynchronous): wr_ptr = rd_ptr = 0, count = 0, rd_data = 0, rd_valid = 0, overflow = underflow = 0; hence empty = 1, full = 0, almost_full = 0
- Reset deassertion is synchronised externally; the block needs no other reset sequencing
- Push latency: a word written at edge N is poppable at edge N+1; empty falls after edge N
- Pop latency: rd_en sampled at edge N -> rd_data and rd_valid valid after edge N; rd_valid low after N+1 unless popped again
- Back-to-back pops every cycle sustain one word per cycle
- Status flags and count reflect the state after the most recent edge
- Reset mid-operation: all in-flight pushes and pops are discarded; stored words are lost

## Structure
- Shared package uart_pkg: UART_DATA_W default (8), UART_TXF_DEPTH default (16), and a function computing the AF_LEVEL default
- Sub-module tx_fifo_mem: DEPTH x DATA_W simple dual-port RAM with synchronous write and synchronous registered read; no reset on the array, so it infers block or distributed RAM
- Top holds pointers, count, flags and the push_ok/pop_ok arbitration
- Elaboration-time check: DEPTH not a power of two or AF_LEVEL out of range triggers $error

## Test plan
- Reset, then push 0x41..0x50 (16 words, DEPTH=16) -> full=1 and count=16 after the 16th edge; almost_full=1 from count=14; pop 16 -> rd_data 0x41..0x50 in order, rd_valid each cycle, empty=1 at end
- Push while full (0xAA) without a pop -> word dropped, overflow=1, count stays 16, next pop still returns the oldest word
- Full FIFO, wr_en & rd_en same cycle with 0x77 -> oldest word popped, count=16, overflow=0; 0x77 appears as the 16th subsequent pop
- Empty FIFO, rd_en alone -> underflow=1, rd_valid=0, rd_data unchanged; rd_en & wr_en(0x33) -> count=1, next pop returns 0x33
- 40 push/pop pairs with interleaved idle cycles -> pointers wrap twice, data in order, count never exceeds DEPTH; repeat with DEPTH=4, DATA_W=9
- areset pulsed mid-stream at count=5, and clr asserted concurrently with wr_en -> count=0, empty=1, flags 0, the concurrent write is not stored
